// File: rtl/otter_cu_pkg.sv
// Shared encodings for the OTTER multicycle control unit: FSM states,
// immediate-type selects, RV32I major opcodes and the MRET funct12.
package otter_cu_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0]  F3_PRIV  = 3'b000;
    localparam logic [2:0]  F3_CSRRW = 3'b001;
    localparam logic [11:0] MRET_IMM = 12'h302;

    // True for opcodes whose single EXEC cycle writes rd.
    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode == OPC_OP)  || (opcode == OPC_OP_IMM) ||
               (opcode == OPC_LUI) || (opcode == OPC_AUIPC)  ||
               (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit <-> datapath bundle. The control unit (master) consumes the
// instruction, interrupt and memory-acknowledge inputs and drives every strobe.
//
// Data-memory handshake: a load or store request (MEM_RDEN2 / MEM_WE2) is held
// high every cycle until the memory answers with MEM_READY=1 in the same cycle;
// that cycle completes the access, and the request drops on the next edge.
interface otter_cu_fsm_if;
    import otter_cu_pkg::*;

    logic [31:0] IR;
    logic        INTR;
    logic        CSR_MIE;
    logic        MEM_READY;
    logic        PC_WE;
    logic        RF_WE;
    logic        MEM_RDEN1;
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic        CSR_WE;
    logic        INT_TAKEN;
    logic        MRET_EXEC;
    imm_sel_t    IMM_SEL;
    logic [2:0]  FSM_STATE;

    modport master (
        input  IR, INTR, CSR_MIE, MEM_READY,
        output PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
               INT_TAKEN, MRET_EXEC, IMM_SEL, FSM_STATE
    );

    modport slave (
        output IR, INTR, CSR_MIE, MEM_READY,
        input  PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
               INT_TAKEN, MRET_EXEC, IMM_SEL, FSM_STATE
    );

endinterface

// File: rtl/otter_imm_sel_decode.sv
// Opcode -> immediate-format select for the datapath immediate mux.
// Purely combinational so a pipelined decoder can reuse it as-is.
module otter_imm_sel_decode
    import otter_cu_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_sel_t   imm_sel
);

    // Map each major opcode onto the immediate format it carries.
    always_comb begin
        imm_sel = IMM_I;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_sel = IMM_I;
            OPC_STORE:                                   imm_sel = IMM_S;
            OPC_BRANCH:                                  imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:                          imm_sel = IMM_U;
            OPC_JAL:                                     imm_sel = IMM_J;
            default:                                     imm_sel = IMM_I;
        endcase
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR].
// Strobes are Moore/Mealy combinational from state, IR and MEM_READY.
// Interrupts are only taken at instruction completion, so a stalled load or
// store always finishes before entry; INTR is a level and is simply
// re-evaluated every completion cycle.
module otter_cu_fsm
    import otter_cu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    otter_cu_fsm_if.master bus
);

    state_t     state;
    state_t     next_state;
    state_t     done_state;
    imm_sel_t   imm_dec;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [11:0] funct12;

    logic pc_we, rf_we, rden1, rden2, we2, csr_we, int_taken, mret_exec;

    assign opcode  = bus.IR[6:0];
    assign func3   = bus.IR[14:12];
    assign funct12 = bus.IR[31:20];

    // Where to go once the current instruction retires.
    assign done_state = (bus.INTR && bus.CSR_MIE) ? ST_INTR : ST_FETCH;

    otter_imm_sel_decode u_imm_sel (
        .opcode  (opcode),
        .imm_sel (imm_dec)
    );

    // State register; reset drops straight to INIT without a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_INIT;
        else     state <= next_state;
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        rden1      = 1'b0;
        rden2      = 1'b0;
        we2        = 1'b0;
        csr_we     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        case (state)
            ST_INIT: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                rden1      = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OPC_LOAD) begin
                    // Address goes out now; data is captured in WB.
                    rden2      = 1'b1;
                    next_state = ST_WB;
                end else if (opcode == OPC_STORE) begin
                    we2 = 1'b1;
                    if (bus.MEM_READY) begin
                        pc_we      = 1'b1;
                        next_state = done_state;
                    end
                end else if (writes_rd(opcode)) begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = done_state;
                end else if (opcode == OPC_SYSTEM) begin
                    pc_we      = 1'b1;
                    next_state = done_state;
                    if (func3 == F3_CSRRW) begin
                        csr_we = 1'b1;
                        rf_we  = 1'b1;
                    end else if (func3 == F3_PRIV && funct12 == MRET_IMM) begin
                        mret_exec = 1'b1;
                    end
                end else begin
                    // BRANCH and unknown opcodes only advance the PC.
                    pc_we      = 1'b1;
                    next_state = done_state;
                end
            end
            ST_WB: begin
                rden2 = 1'b1;
                if (bus.MEM_READY) begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = done_state;
                end
            end
            ST_INTR: begin
                int_taken  = 1'b1;
                pc_we      = 1'b1;
                next_state = ST_FETCH;
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    assign bus.PC_WE     = pc_we;
    assign bus.RF_WE     = rf_we;
    assign bus.MEM_RDEN1 = rden1;
    assign bus.MEM_RDEN2 = rden2;
    assign bus.MEM_WE2   = we2;
    assign bus.CSR_WE    = csr_we;
    assign bus.INT_TAKEN = int_taken;
    assign bus.MRET_EXEC = mret_exec;
    // INIT forces every output low, including the immediate select.
    assign bus.IMM_SEL   = (state == ST_INIT) ? IMM_I : imm_dec;
    assign bus.FSM_STATE = state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: directed instruction sequences, an instruction-level
// reference model compared every falling edge, and literal spot checks.
module tb_otter_cu_fsm;

    logic CLK = 1'b0;
    logic RST;
    int   tests = 0;
    int   fails = 0;

    otter_cu_fsm_if bus();

    otter_cu_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Instructions are classified by what they do, then each phase's strobes
    // follow from that class.  Phase numbers are the published FSM_STATE codes.
    typedef enum {K_LOAD, K_STORE, K_REG, K_BRANCH, K_CSRRW, K_MRET, K_NOP} kind_e;

    function automatic kind_e classify(input logic [31:0] ir);
        case (ir[6:0])
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return K_REG;
            7'b1100011: return K_BRANCH;
            7'b1110011: begin
                if (ir[14:12] == 3'b001) return K_CSRRW;
                if (ir[14:12] == 3'b000 && ir[31:20] == 12'h302) return K_MRET;
                return K_NOP;
            end
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [31:0] ir);
        case (ir[6:0])
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    // Packed as {PC_WE,RF_WE,RDEN1,RDEN2,WE2,CSR_WE,INT_TAKEN,MRET,IMM_SEL,FSM_STATE}.
    function automatic logic [13:0] model_out(input int ph, input logic [31:0] ir, input logic ready);
        kind_e k;
        logic pc, rf, r1, r2, w2, cw, it, mr;
        logic [2:0] imm;
        k  = classify(ir);
        pc = 0; rf = 0; r1 = 0; r2 = 0; w2 = 0; cw = 0; it = 0; mr = 0;
        if (ph == 1) r1 = 1;
        if (ph == 2) begin
            r2 = (k == K_LOAD);
            w2 = (k == K_STORE);
            pc = (k != K_LOAD) && !(k == K_STORE && !ready);
            rf = (k == K_REG) || (k == K_CSRRW);
            cw = (k == K_CSRRW);
            mr = (k == K_MRET);
        end
        if (ph == 3) begin
            r2 = 1;
            rf = ready;
            pc = ready;
        end
        if (ph == 4) begin
            it = 1;
            pc = 1;
        end
        imm = (ph == 0) ? 3'd0 : imm_of(ir);
        return {pc, rf, r1, r2, w2, cw, it, mr, imm, 3'(ph)};
    endfunction

    function automatic int model_next(input int ph, input logic [31:0] ir,
                                      input logic intr, input logic mie, input logic ready);
        kind_e k;
        int    retire;
        k      = classify(ir);
        retire = (intr && mie) ? 4 : 1;
        case (ph)
            0: return 1;
            1: return 2;
            2: begin
                if (k == K_LOAD) return 3;
                if (k == K_STORE && !ready) return 2;
                return retire;
            end
            3: return ready ? retire : 3;
            default: return 1;
        endcase
    endfunction

    int m_phase;

    always @(posedge CLK or posedge RST) begin
        if (RST) m_phase <= 0;
        else     m_phase <= model_next(m_phase, bus.IR, bus.INTR, bus.CSR_MIE, bus.MEM_READY);
    end

    // ---------------- per-cycle compare ----------------
    logic [13:0] dut_vec;
    assign dut_vec = {bus.PC_WE, bus.RF_WE, bus.MEM_RDEN1, bus.MEM_RDEN2, bus.MEM_WE2,
                      bus.CSR_WE, bus.INT_TAKEN, bus.MRET_EXEC, 3'(bus.IMM_SEL), bus.FSM_STATE};

    always @(negedge CLK) begin
        chk("cycle_vs_model", 32'(dut_vec), 32'(model_out(m_phase, bus.IR, bus.MEM_READY)));
        chk("one_mem_strobe", 32'(bus.MEM_RDEN1 + bus.MEM_RDEN2 + bus.MEM_WE2 <= 1), 32'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        RST           = 1'b1;
        bus.IR        = 32'h0;
        bus.INTR      = 1'b0;
        bus.CSR_MIE   = 1'b0;
        bus.MEM_READY = 1'b0;
        tick(); tick();
        RST = 1'b0;
        at_neg();
        chk("reset_state", 32'(bus.FSM_STATE), 32'd0);
        chk("reset_outputs", 32'(dut_vec), 32'd0);

        // Mid-EXEC asynchronous reset on addi.
        tick(); bus.IR = 32'h00500093; at_neg();
        chk("fetch_rden1", 32'(bus.MEM_RDEN1), 32'd1);
        chk("fetch_pc_we", 32'(bus.PC_WE), 32'd0);
        tick(); at_neg();
        chk("exec_state_pre_rst", 32'(bus.FSM_STATE), 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.FSM_STATE), 32'd0);
        chk("async_rst_outputs", 32'(dut_vec), 32'd0);
        tick(); RST = 1'b0; at_neg();
        chk("post_rst_init", 32'(bus.FSM_STATE), 32'd0);
        tick(); at_neg();
        chk("post_rst_fetch", 32'(bus.FSM_STATE), 32'd1);
        chk("post_rst_rden1", 32'(bus.MEM_RDEN1), 32'd1);

        // addi x1,x0,5
        tick(); at_neg();
        chk("addi_exec", 32'(dut_vec), 32'b11000000000010);
        tick(); bus.IR = 32'h0000A103; at_neg();
        chk("addi_to_fetch", 32'(bus.FSM_STATE), 32'd1);

        // lw with two stalled WB cycles
        tick(); at_neg();
        chk("lw_exec_rden2", 32'(bus.MEM_RDEN2), 32'd1);
        chk("lw_exec_pc_we", 32'(bus.PC_WE), 32'd0);
        tick(); at_neg();
        chk("lw_wb1_rf_we", 32'(bus.RF_WE), 32'd0);
        tick(); at_neg();
        chk("lw_wb2_state", 32'(bus.FSM_STATE), 32'd3);
        tick(); bus.MEM_READY = 1'b1; at_neg();
        chk("lw_wb3", 32'(dut_vec), 32'b11010000000011);
        tick(); bus.MEM_READY = 1'b0; bus.IR = 32'h0020A023; at_neg();
        chk("lw_to_fetch", 32'(bus.FSM_STATE), 32'd1);

        // sw stalled one cycle
        tick(); at_neg();
        chk("sw_exec1", 32'(dut_vec), 32'b00001000001010);
        tick(); bus.MEM_READY = 1'b1; at_neg();
        chk("sw_exec2", 32'(dut_vec), 32'b10001000001010);
        tick(); bus.MEM_READY = 1'b0; bus.IR = 32'h00208463;
        bus.INTR = 1'b1; bus.CSR_MIE = 1'b1; at_neg();

        // beq with interrupt enabled, then disabled
        tick(); at_neg();
        chk("beq_exec", 32'(dut_vec), 32'b10000000010010);
        tick(); at_neg();
        chk("beq_intr", 32'(dut_vec), 32'b10000010010100);
        tick(); bus.CSR_MIE = 1'b0; at_neg();
        chk("intr_to_fetch", 32'(bus.FSM_STATE), 32'd1);
        tick(); at_neg();
        chk("beq_nomie_pc_we", 32'(bus.PC_WE), 32'd1);
        tick(); bus.INTR = 1'b0; bus.IR = 32'h30200073; at_neg();
        chk("beq_nomie_fetch", 32'(bus.FSM_STATE), 32'd1);
        chk("beq_nomie_no_int", 32'(bus.INT_TAKEN), 32'd0);

        // mret then csrrw
        tick(); at_neg();
        chk("mret_exec", 32'(dut_vec), 32'b10000001000010);
        tick(); bus.IR = 32'h34029073; at_neg();
        tick(); at_neg();
        chk("csrrw_exec", 32'(dut_vec), 32'b11000100000010);

        // Store stalled with interrupt held: finishes first, then INTR.
        tick(); bus.IR = 32'h0020A023; bus.INTR = 1'b1; bus.CSR_MIE = 1'b1; at_neg();
        tick(); at_neg();
        chk("sw_irq_stall_pc_we", 32'(bus.PC_WE), 32'd0);
        tick(); bus.MEM_READY = 1'b1; at_neg();
        tick(); bus.MEM_READY = 1'b0; bus.INTR = 1'b0; at_neg();
        chk("sw_irq_taken", 32'(bus.INT_TAKEN), 32'd1);

        // Load with an interrupt pulse that drops before completion.
        tick(); bus.IR = 32'h0000A103; at_neg();
        tick(); bus.INTR = 1'b1; at_neg();
        tick(); bus.INTR = 1'b0; at_neg();
        tick(); bus.MEM_READY = 1'b1; at_neg();
        chk("lw_pulse_wb_rf_we", 32'(bus.RF_WE), 32'd1);
        tick(); bus.MEM_READY = 1'b0; bus.IR = 32'h0000007F; at_neg();
        chk("lw_pulse_ignored", 32'(bus.FSM_STATE), 32'd1);

        // Unknown opcode, then ecall: PC advance only.
        tick(); at_neg();
        chk("unknown_exec", 32'(dut_vec), 32'b10000000000010);
        tick(); bus.IR = 32'h00000073; at_neg();
        tick(); at_neg();
        chk("ecall_exec", 32'(dut_vec), 32'b10000000000010);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
